rr_arb_requester: RTL and testbench

Requester-side front end for the 4-way round-robin arbiter. It buffers per-port transactions in small FIFOs, drives req[] toward the arbiter, and consumes the one-hot grant[] to pop the granted port's head entry. The popped entry goes onto a single shared output stage with a valid/ready handshake. It sits between the client ports and the arbitrated shared resource.

---
 rtl/rr_arb_requester_if.sv | 25 ++
 rtl/rr_arb_requester.sv | 83 ++++++++
 tb/tb_rr_arb_requester.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rr_arb_requester_if.sv
// rr_arb_requester_if: client push ports, arbiter req/grant and shared output handshake
interface rr_arb_requester_if #(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 8
);
   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   logic [N_PORTS-1:0]        in_valid;
   logic [N_PORTS*DATA_W-1:0] in_data;
   logic [N_PORTS-1:0]        in_ready;
   logic [N_PORTS-1:0]        req;
   logic [N_PORTS-1:0]        grant;
   logic                      out_valid;
   logic                      out_ready;
   logic [PW-1:0]             out_port;
   logic [DATA_W-1:0]         out_data;
   logic                      proto_err;
   modport master (
      output in_valid, in_data, grant, out_ready,
      input  in_ready, req, out_valid, out_port, out_data, proto_err
   );
   modport slave (
      input  in_valid, in_data, grant, out_ready,
      output in_ready, req, out_valid, out_port, out_data, proto_err
   );
endinterface

// File: rtl/rr_arb_requester.sv
// rr_arb_requester: per-port FIFOs feeding an arbiter; the granted head moves to a shared output register
module rr_arb_requester #(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 4
) (
   input logic clk,
   input logic reset,
   rr_arb_requester_if.slave bus
);
   localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam int AW = $clog2(DEPTH);
   logic [DATA_W-1:0]  mem [N_PORTS][DEPTH];
   logic [AW-1:0]      wptr [N_PORTS];
   logic [AW-1:0]      rptr [N_PORTS];
   logic [AW:0]        cnt [N_PORTS];
   logic [N_PORTS-1:0] push, pop, req;
   logic               onehot, hit, err, out_free, accept;
   logic               out_valid, proto_err;
   logic [PW-1:0]      gidx, out_port;
   logic [DATA_W-1:0]  head, out_data;
   for (genvar g = 0; g < N_PORTS; g++) begin : g_flags
      assign bus.in_ready[g] = cnt[g] != (AW+1)'(DEPTH);
      assign req[g]          = cnt[g] != '0;
      assign push[g]         = bus.in_valid[g] && bus.in_ready[g];
   end
   assign bus.req       = req;
   assign bus.out_valid = out_valid;
   assign bus.out_port  = out_port;
   assign bus.out_data  = out_data;
   assign bus.proto_err = proto_err;
   // Multi-bit grants and grants to empty ports are both errors; a stalled legal grant is not.
   assign onehot   = (bus.grant != '0) && ((bus.grant & (bus.grant - N_PORTS'(1))) == '0);
   assign hit      = |(bus.grant & req);
   assign err      = ((bus.grant != '0) && !onehot) || |(bus.grant & ~req);
   assign out_free = !out_valid || bus.out_ready;
   assign accept   = onehot && hit && out_free;
   assign pop      = accept ? bus.grant : '0;
   always_comb begin
      gidx = '0;
      head = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (bus.grant[i]) begin
            gidx = PW'(i);
            head = mem[i][rptr[i]];
         end
      end
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_PORTS; i++) begin
         if (!reset) begin
            wptr[i] <= '0;
            rptr[i] <= '0;
            cnt[i]  <= '0;
         end else begin
            wptr[i] <= wptr[i] + AW'(push[i]);
            rptr[i] <= rptr[i] + AW'(pop[i]);
            cnt[i]  <= cnt[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
         end
      end
   end
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_PORTS; i++)
         if (push[i]) mem[i][wptr[i]] <= bus.in_data[i*DATA_W +: DATA_W];
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_port  <= '0;
         out_data  <= '0;
         proto_err <= 1'b0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_port  <= gidx;
            out_data  <= head;
         end else if (bus.out_ready) begin
            out_valid <= 1'b0;
         end
         if (err) proto_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_rr_arb_requester.sv
// tb_rr_arb_requester: directed scenario tasks with hand-computed expectations
module tb_rr_arb_requester;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   pass_cnt = 0;
   int   total = 0;
   rr_arb_requester_if #(.N_PORTS(4), .DATA_W(8)) bus ();
   rr_arb_requester #(.N_PORTS(4), .DATA_W(8), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic push_one(input int p, input logic [7:0] d);
      bus.in_valid = 4'(1 << p);
      bus.in_data[p*8 +: 8] = d;
      @(negedge clk);
      bus.in_valid = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.in_valid = '0;
      bus.grant = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.in_valid = 4'hF;
      bus.in_data = 32'h44332211;
      bus.grant = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (bus.req !== 4'h0) $display("FAIL reset_req got=%h exp=0", bus.req); else pass_cnt++;
      total++; if (bus.in_ready !== 4'hF) $display("FAIL reset_in_ready got=%h exp=f", bus.in_ready); else pass_cnt++;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
      total++; if (bus.proto_err !== 1'b0) $display("FAIL reset_proto_err got=%b exp=0", bus.proto_err); else pass_cnt++;
      total++; if (bus.out_data !== 8'h00 || bus.out_port !== 2'd0) $display("FAIL reset_out got=%0d/%h exp=0/00", bus.out_port, bus.out_data); else pass_cnt++;
      bus.in_valid = '0;
      reset = 1'b1;
      @(negedge clk);
      total++; if (bus.req !== 4'h0) $display("FAIL reset_nothing_stored got=%h exp=0", bus.req); else pass_cnt++;
   endtask

   task automatic test_single_port();
      logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
      push_one(2, 8'h11);
      total++; if (bus.req !== 4'b0100) $display("FAIL single_req got=%b exp=0100", bus.req); else pass_cnt++;
      push_one(2, 8'h22);
      push_one(2, 8'h33);
      bus.grant = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_port !== 2'd2 || bus.out_data !== exp_d[k])
            $display("FAIL single_pop%0d got=%b/%0d/%h exp=1/2/%h", k, bus.out_valid, bus.out_port, bus.out_data, exp_d[k]);
         else pass_cnt++;
      end
      bus.grant = '0;
      total++; if (bus.req !== 4'b0000) $display("FAIL single_req_empty got=%b exp=0000", bus.req); else pass_cnt++;
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", bus.out_valid); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      bus.in_valid = 4'hF;
      bus.in_data = 32'hA3A2A1A0;
      @(negedge clk);
      bus.in_valid = '0;
      total++; if (bus.req !== 4'hF) $display("FAIL rr_req got=%h exp=f", bus.req); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         bus.grant = 4'(1 << i);
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_port !== 2'(i) || bus.out_data !== 8'(8'hA0 + i))
            $display("FAIL rr_out%0d got=%b/%0d/%h exp=1/%0d/%h", i, bus.out_valid, bus.out_port, bus.out_data, i, 8'(8'hA0 + i));
         else pass_cnt++;
      end
      bus.grant = '0;
      total++; if (bus.req !== 4'h0) $display("FAIL rr_req_end got=%h exp=0", bus.req); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_full_wrap();
      logic [7:0] exp_pop [6] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61};
      for (int k = 0; k < 4; k++) push_one(1, 8'(8'h50 + k));
      total++; if (bus.in_ready[1] !== 1'b0) $display("FAIL full_in_ready got=%b exp=0", bus.in_ready[1]); else pass_cnt++;
      push_one(1, 8'h99);
      total++; if (bus.in_ready !== 4'b1101 || bus.req !== 4'b0010) $display("FAIL full_drop got=%b/%b exp=1101/0010", bus.in_ready, bus.req); else pass_cnt++;
      for (int k = 0; k < 6; k++) begin
         bus.grant = 4'b0010;
         @(negedge clk);
         bus.grant = '0;
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_port !== 2'd1 || bus.out_data !== exp_pop[k])
            $display("FAIL wrap_pop%0d got=%b/%0d/%h exp=1/1/%h", k, bus.out_valid, bus.out_port, bus.out_data, exp_pop[k]);
         else pass_cnt++;
         push_one(1, 8'(8'h60 + k));
         total++; if (bus.in_ready[1] !== 1'b0) $display("FAIL wrap_full%0d got=%b exp=0", k, bus.in_ready[1]); else pass_cnt++;
      end
      bus.grant = 4'b0010;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (bus.out_data !== 8'(8'h62 + k)) $display("FAIL wrap_drain%0d got=%h exp=%h", k, bus.out_data, 8'(8'h62 + k)); else pass_cnt++;
      end
      bus.grant = '0;
      total++; if (bus.req !== 4'h0 || bus.proto_err !== 1'b0) $display("FAIL wrap_end got=%b/%b exp=0000/0", bus.req, bus.proto_err); else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_stall();
      bus.in_valid = 4'b1001;
      bus.in_data = 32'hC3_00_00_C0;
      @(negedge clk);
      bus.in_valid = '0;
      bus.grant = 4'b1000;
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC3) $display("FAIL stall_load got=%b/%h exp=1/c3", bus.out_valid, bus.out_data); else pass_cnt++;
      bus.out_ready = 1'b0;
      bus.grant = 4'b0001;
      repeat (2) begin
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.out_port !== 2'd3 || bus.out_data !== 8'hC3 || bus.req !== 4'b0001 || bus.proto_err !== 1'b0)
            $display("FAIL stall_hold got=%b/%0d/%h/%b/%b exp=1/3/c3/0001/0", bus.out_valid, bus.out_port, bus.out_data, bus.req, bus.proto_err);
         else pass_cnt++;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.grant = '0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_port !== 2'd0 || bus.out_data !== 8'hC0 || bus.req !== 4'b0000)
         $display("FAIL stall_release got=%b/%0d/%h/%b exp=1/0/c0/0000", bus.out_valid, bus.out_port, bus.out_data, bus.req);
      else pass_cnt++;
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0) $display("FAIL stall_drain got=%b exp=0", bus.out_valid); else pass_cnt++;
   endtask

   task automatic test_errors();
      bus.in_valid = 4'b0011;
      bus.in_data = 32'h0000_B1B0;
      @(negedge clk);
      bus.in_valid = '0;
      bus.grant = 4'b0011;
      @(negedge clk);
      bus.grant = '0;
      total++;
      if (bus.proto_err !== 1'b1 || bus.req !== 4'b0011 || bus.out_valid !== 1'b0)
         $display("FAIL err_multi got=%b/%b/%b exp=1/0011/0", bus.proto_err, bus.req, bus.out_valid);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      total++; if (bus.proto_err !== 1'b1) $display("FAIL err_multi_sticky got=%b exp=1", bus.proto_err); else pass_cnt++;
      do_reset();
      total++; if (bus.proto_err !== 1'b0 || bus.req !== 4'b0000) $display("FAIL err_reset1 got=%b/%b exp=0/0000", bus.proto_err, bus.req); else pass_cnt++;
      bus.grant = 4'b1000;
      @(negedge clk);
      bus.grant = '0;
      total++; if (bus.proto_err !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL err_no_req got=%b/%b exp=1/0", bus.proto_err, bus.out_valid); else pass_cnt++;
      repeat (3) @(negedge clk);
      total++; if (bus.proto_err !== 1'b1) $display("FAIL err_no_req_sticky got=%b exp=1", bus.proto_err); else pass_cnt++;
      do_reset();
      total++; if (bus.proto_err !== 1'b0) $display("FAIL err_reset2 got=%b exp=0", bus.proto_err); else pass_cnt++;
   endtask

   initial begin
      bus.in_valid = '0;
      bus.in_data = '0;
      bus.grant = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_single_port();
      test_round_robin();
      test_full_wrap();
      test_stall();
      test_errors();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
